fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 40 ++++
 rtl/fetch_sequencer_decoder.sv | 11 +
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared SAP-2 definitions: sequencer state encoding, halt opcode and the
// instruction length table used by both the fetch and control sequencers.
package fetch_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        F_ADDR,
        F_INC,
        F_MEM,
        DECODE,
        O1_ADDR,
        O1_INC,
        O1_MEM,
        O2_ADDR,
        O2_INC,
        O2_MEM,
        EXECUTE,
        HALT
    } state_t;

    localparam logic [7:0] HLT_OPCODE = 8'h76;

    // Total instruction length in bytes (opcode plus immediate/address bytes).
    function automatic logic [1:0] opcodeLength(input logic [7:0] op);
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hD3, 8'hDB:
                return 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
            8'hC3, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2,
            8'hFA, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4,
            8'hFC, 8'hCD:
                return 2'd3;
            default:
                return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer_decoder.sv
// Combinational opcode length decoder built on the shared SAP-2 length table.
module opcode_length_decoder
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] BYTES
);

    assign BYTES = opcodeLength(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// SAP-2 fetch sequencer: fetches opcode and operand bytes, hands off to the
// execute controller, and halts on HLT or on an execute-phase watchdog timeout.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [7:0] HLT_OP   = HLT_OPCODE,
    parameter int         MAX_EXEC = 16
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       RUN,
    input  logic [7:0] opcode,
    input  logic       EXEC_DONE,
    output logic       nEp,
    output logic       nLm,
    output logic       Cp,
    output logic       nCE,
    output logic       nLi,
    output logic [1:0] nLo,
    output logic       EXEC,
    output logic [1:0] BYTES,
    output logic       HALTED,
    output logic       FAULT
);

    state_t     state      = IDLE;
    state_t     stateNext;
    logic [1:0] bytesReg   = 2'd1;
    logic [4:0] execCount  = 5'd0;
    logic       faultReg   = 1'b0;
    logic       nEpReg     = 1'b1;
    logic       nLmReg     = 1'b1;
    logic       cpReg      = 1'b0;
    logic       nCeReg     = 1'b1;
    logic       nLiReg     = 1'b1;
    logic [1:0] nLoReg     = 2'b11;
    logic       execReg    = 1'b0;
    logic       haltedReg  = 1'b0;
    logic [1:0] decodedBytes;
    logic       watchdogExpired;

    opcode_length_decoder lengthDecoder (
        .opcode (opcode),
        .BYTES  (decodedBytes)
    );

    assign watchdogExpired = (MAX_EXEC != 0) && (execCount == 5'(MAX_EXEC - 1));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (RUN) stateNext = F_ADDR;
            F_ADDR:  stateNext = F_INC;
            F_INC:   stateNext = F_MEM;
            F_MEM:   stateNext = DECODE;
            DECODE: begin
                if (opcode == HLT_OP)           stateNext = HALT;
                else if (decodedBytes == 2'd1)  stateNext = EXECUTE;
                else                            stateNext = O1_ADDR;
            end
            O1_ADDR: stateNext = O1_INC;
            O1_INC:  stateNext = O1_MEM;
            O1_MEM:  stateNext = (bytesReg == 2'd3) ? O2_ADDR : EXECUTE;
            O2_ADDR: stateNext = O2_INC;
            O2_INC:  stateNext = O2_MEM;
            O2_MEM:  stateNext = EXECUTE;
            EXECUTE: begin
                if (EXEC_DONE)            stateNext = F_ADDR;
                else if (watchdogExpired) stateNext = HALT;
            end
            HALT:    stateNext = HALT;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= IDLE;
            bytesReg  <= 2'd1;
            execCount <= 5'd0;
            faultReg  <= 1'b0;
            nEpReg    <= 1'b1;
            nLmReg    <= 1'b1;
            cpReg     <= 1'b0;
            nCeReg    <= 1'b1;
            nLiReg    <= 1'b1;
            nLoReg    <= 2'b11;
            execReg   <= 1'b0;
            haltedReg <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == DECODE) bytesReg <= decodedBytes;
            if (stateNext == EXECUTE && state != EXECUTE)
                execCount <= 5'd0;
            else if (state == EXECUTE && execCount != 5'h1F)
                execCount <= execCount + 5'd1;
            if (state == EXECUTE && stateNext == HALT) faultReg <= 1'b1;
            nEpReg    <= !(stateNext inside {F_ADDR, O1_ADDR, O2_ADDR});
            nLmReg    <= !(stateNext inside {F_ADDR, O1_ADDR, O2_ADDR});
            cpReg     <= (stateNext inside {F_INC, O1_INC, O2_INC});
            nCeReg    <= !(stateNext inside {F_MEM, O1_MEM, O2_MEM});
            nLiReg    <= (stateNext != F_MEM);
            nLoReg    <= {stateNext != O2_MEM, stateNext != O1_MEM};
            execReg   <= (stateNext == EXECUTE);
            haltedReg <= (stateNext == HALT);
        end
    end

    assign nEp    = nEpReg;
    assign nLm    = nLmReg;
    assign Cp     = cpReg;
    assign nCE    = nCeReg;
    assign nLi    = nLiReg;
    assign nLo    = nLoReg;
    assign EXEC   = execReg;
    assign BYTES  = bytesReg;
    assign HALTED = haltedReg;
    assign FAULT  = faultReg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: every cycle of each
// instruction is compared against a hand-computed output vector.
module tb_fetch_sequencer;

    logic       CLK;
    logic       CLR;
    logic       RUN;
    logic [7:0] opcode;
    logic       EXEC_DONE;
    logic       nEp, nLm, Cp, nCE, nLi, EXEC, HALTED, FAULT;
    logic [1:0] nLo;
    logic [1:0] BYTES;

    int passCount  = 0;
    int checkCount = 0;

    // Vector order: {nEp, nLm, Cp, nCE, nLi, nLo[1:0], EXEC, HALTED, FAULT}
    localparam logic [9:0] O_IDLE  = 10'b1101111000;
    localparam logic [9:0] O_ADDR  = 10'b0001111000;
    localparam logic [9:0] O_INC   = 10'b1111111000;
    localparam logic [9:0] O_FMEM  = 10'b1100011000;
    localparam logic [9:0] O_DEC   = 10'b1101111000;
    localparam logic [9:0] O_O1MEM = 10'b1100110000;
    localparam logic [9:0] O_O2MEM = 10'b1100101000;
    localparam logic [9:0] O_EXEC  = 10'b1101111100;
    localparam logic [9:0] O_HALT  = 10'b1101111010;
    localparam logic [9:0] O_FAULT = 10'b1101111011;

    fetch_sequencer #(
        .HLT_OP   (8'h76),
        .MAX_EXEC (16)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .RUN       (RUN),
        .opcode    (opcode),
        .EXEC_DONE (EXEC_DONE),
        .nEp       (nEp),
        .nLm       (nLm),
        .Cp        (Cp),
        .nCE       (nCE),
        .nLi       (nLi),
        .nLo       (nLo),
        .EXEC      (EXEC),
        .BYTES     (BYTES),
        .HALTED    (HALTED),
        .FAULT     (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [9:0] expOut, input logic [1:0] expBytes);
        logic [9:0] obsOut;
        obsOut = {nEp, nLm, Cp, nCE, nLi, nLo, EXEC, HALTED, FAULT};
        checkCount++;
        assert (obsOut === expOut) passCount++;
        else $error("FAIL %s outputs observed=%b expected=%b", tag, obsOut, expOut);
        checkCount++;
        assert (BYTES === expBytes) passCount++;
        else $error("FAIL %s BYTES observed=%0d expected=%0d", tag, BYTES, expBytes);
    endtask

    task automatic applyStimulus(input string name, input int cyc, input logic [9:0] expOut, input logic [1:0] expBytes);
        @(posedge CLK);
        #1;
        checkOutput($sformatf("%s_c%0d", name, cyc), expOut, expBytes);
    endtask

    initial begin
        CLR = 1'b1; RUN = 1'b0; opcode = 8'h00; EXEC_DONE = 1'b0;
        applyStimulus("reset", 0, O_IDLE, 2'd1);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        applyStimulus("clr_priority", 0, O_IDLE, 2'd1);

        // ADD B: single byte, EXEC_DONE on first execute cycle
        CLR = 1'b0; EXEC_DONE = 1'b0; opcode = 8'h80;
        applyStimulus("add", 1, O_ADDR, 2'd1);
        RUN = 1'b0;
        applyStimulus("add", 2, O_INC,  2'd1);
        applyStimulus("add", 3, O_FMEM, 2'd1);
        applyStimulus("add", 4, O_DEC,  2'd1);
        applyStimulus("add", 5, O_EXEC, 2'd1);
        EXEC_DONE = 1'b1; opcode = 8'h3E;

        // MVI A: two bytes; a stray EXEC_DONE during fetch must be ignored
        applyStimulus("mvi", 1, O_ADDR, 2'd1);
        EXEC_DONE = 1'b0;
        applyStimulus("mvi", 2, O_INC,  2'd1);
        EXEC_DONE = 1'b1;
        applyStimulus("mvi", 3, O_FMEM, 2'd1);
        EXEC_DONE = 1'b0;
        applyStimulus("mvi", 4, O_DEC,   2'd1);
        applyStimulus("mvi", 5, O_ADDR,  2'd2);
        applyStimulus("mvi", 6, O_INC,   2'd2);
        applyStimulus("mvi", 7, O_O1MEM, 2'd2);
        applyStimulus("mvi", 8, O_EXEC,  2'd2);
        EXEC_DONE = 1'b1; opcode = 8'hCD;

        // CALL: three bytes, then EXEC_DONE withheld to trip the watchdog
        applyStimulus("call", 1, O_ADDR, 2'd2);
        EXEC_DONE = 1'b0;
        applyStimulus("call", 2,  O_INC,   2'd2);
        applyStimulus("call", 3,  O_FMEM,  2'd2);
        applyStimulus("call", 4,  O_DEC,   2'd2);
        applyStimulus("call", 5,  O_ADDR,  2'd3);
        applyStimulus("call", 6,  O_INC,   2'd3);
        applyStimulus("call", 7,  O_O1MEM, 2'd3);
        applyStimulus("call", 8,  O_ADDR,  2'd3);
        applyStimulus("call", 9,  O_INC,   2'd3);
        applyStimulus("call", 10, O_O2MEM, 2'd3);
        applyStimulus("call", 11, O_EXEC,  2'd3);
        for (int i = 2; i <= 16; i++) applyStimulus("watchdog_exec", i, O_EXEC, 2'd3);
        applyStimulus("watchdog_fault", 17, O_FAULT, 2'd3);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        applyStimulus("fault_hold", 18, O_FAULT, 2'd3);
        RUN = 1'b0; EXEC_DONE = 1'b0; CLR = 1'b1;
        applyStimulus("fault_clr", 0, O_IDLE, 2'd1);
        CLR = 1'b0;
        applyStimulus("fault_idle", 0, O_IDLE, 2'd1);

        // HLT: halts without fault, ignores RUN and EXEC_DONE until CLR
        opcode = 8'h76; RUN = 1'b1;
        applyStimulus("hlt", 1, O_ADDR, 2'd1);
        RUN = 1'b0;
        applyStimulus("hlt", 2, O_INC,  2'd1);
        applyStimulus("hlt", 3, O_FMEM, 2'd1);
        applyStimulus("hlt", 4, O_DEC,  2'd1);
        applyStimulus("hlt", 5, O_HALT, 2'd1);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        applyStimulus("hlt", 6, O_HALT, 2'd1);
        applyStimulus("hlt", 7, O_HALT, 2'd1);
        RUN = 1'b0; EXEC_DONE = 1'b0; CLR = 1'b1;
        applyStimulus("hlt_clr", 0, O_IDLE, 2'd1);
        CLR = 1'b0;

        // CLR during O1_INC of MVI aborts the fetch before any operand load
        opcode = 8'h3E; RUN = 1'b1;
        applyStimulus("abort", 1, O_ADDR, 2'd1);
        RUN = 1'b0;
        applyStimulus("abort", 2, O_INC,  2'd1);
        applyStimulus("abort", 3, O_FMEM, 2'd1);
        applyStimulus("abort", 4, O_DEC,  2'd1);
        applyStimulus("abort", 5, O_ADDR, 2'd2);
        applyStimulus("abort", 6, O_INC,  2'd2);
        CLR = 1'b1;
        applyStimulus("abort_clr", 7, O_IDLE, 2'd1);
        CLR = 1'b0;
        applyStimulus("abort_idle", 8, O_IDLE, 2'd1);
        applyStimulus("abort_idle", 9, O_IDLE, 2'd1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
